// File: rtl/sakebi_eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, header sizes and the RX framer states.
package sakebi_eth_pkg;

  localparam logic [31:0] CRC32_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB_20E3;
  localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_FCS_LEN    = 4;
  localparam int          ETH_HDR_DA_LEN = 6;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PASS,
    DROP,
    FLUSH
  } rx_state_e;

  // Byte idx of a MAC address in wire order (byte 0 = bits [47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac >> (6'd40 - {idx, 3'b000});
    return sh[7:0];
  endfunction

endpackage

// File: rtl/sakebi_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB first), purely combinational.
module sakebi_crc32_byte
  import sakebi_eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/sakebi_eth_rx_frame.sv
// Recovers Ethernet frames from an unframed byte stream using idle gaps, checks
// FCS/length/destination, and emits a framed stream with the FCS stripped.
module sakebi_eth_rx_frame
  import sakebi_eth_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          IDLE_GAP   = 16,
  parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
  parameter int          PROMISC    = 0,
  parameter int          MIN_LEN    = 64,
  parameter int          MAX_LEN    = 1522
) (
  input  logic                  i_axis_ACLK,
  input  logic                  i_axis_ARESET,
  input  logic                  i_axis_TVALID,
  output logic                  o_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_axis_TDATA,
  output logic                  o_axis_TVALID,
  output logic [DATA_WIDTH-1:0] o_axis_TDATA,
  output logic                  o_axis_TLAST,
  output logic                  o_axis_TUSER,
  output logic                  o_frame_done,
  output logic [2:0]            o_frame_status
);

  localparam int          DL_LEN  = ETH_FCS_LEN + 1;
  localparam logic [15:0] GAP_END = 16'(IDLE_GAP);
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] DA_LAST = 11'(ETH_HDR_DA_LEN - 1);

  rx_state_e   state_q, state_d;
  logic [7:0]  dl_q [DL_LEN];
  logic [7:0]  dl_d [DL_LEN];
  logic [7:0]  dl_shift [DL_LEN];
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] crc_q, crc_d, crc_in, crc_next;
  logic        da_match_q, da_match_d, bc_match_q, bc_match_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d, out_user_q, out_user_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        done_q, done_d;
  logic [2:0]  status_q, status_d;
  logic [7:0]  byte_in;
  logic        take, timeout, fcs_bad, len_bad, accept;

  assign byte_in = i_axis_TDATA;
  // A byte landing in FLUSH is ignored; the idle gap rules that out in practice.
  assign take    = i_axis_TVALID && (state_q != FLUSH);
  assign timeout = !i_axis_TVALID && (gap_cnt_q == GAP_END);
  assign fcs_bad = (crc_q != CRC32_RESIDUE);
  assign len_bad = (byte_cnt_q < MIN_L) || (byte_cnt_q > MAX_L);
  assign crc_in  = (state_q == IDLE) ? 32'hFFFF_FFFF : crc_q;

  sakebi_crc32_byte u_crc (
    .crc_in  (crc_in),
    .data_in (byte_in),
    .crc_out (crc_next)
  );

  assign dl_shift[0] = byte_in;
  genvar gi;
  generate
    for (gi = 1; gi < DL_LEN; gi++) begin : g_dl
      assign dl_shift[gi] = dl_q[gi-1];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    dl_d        = dl_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    crc_d       = crc_q;
    da_match_d  = da_match_q;
    bc_match_d  = bc_match_q;
    out_valid_d = 1'b0;
    out_data_d  = 8'h00;
    out_last_d  = 1'b0;
    out_user_d  = 1'b0;
    done_d      = 1'b0;
    status_d    = 3'b000;
    accept      = 1'b0;

    if (take) begin
      dl_d       = dl_shift;
      byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
      gap_cnt_d  = 16'd0;
      crc_d      = crc_next;
    end else if (state_q != IDLE && state_q != FLUSH) begin
      gap_cnt_d = gap_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d    = HDR;
          byte_cnt_d = 11'd1;
          da_match_d = (byte_in == mac_byte(MAC_ADDR, 3'd0));
          bc_match_d = (byte_in == mac_byte(BROADCAST_MAC, 3'd0));
        end
      end
      HDR: begin
        if (take) begin
          da_match_d = da_match_q && (byte_in == mac_byte(MAC_ADDR, byte_cnt_q[2:0]));
          bc_match_d = bc_match_q && (byte_in == mac_byte(BROADCAST_MAC, byte_cnt_q[2:0]));
          if (byte_cnt_q == DA_LAST) begin
            accept      = da_match_d || bc_match_d || (PROMISC != 0);
            state_d     = accept ? PASS : DROP;
            out_valid_d = accept;
            out_data_d  = accept ? dl_q[DL_LEN-1] : 8'h00;
          end
        end else if (timeout) begin
          done_d   = 1'b1;
          status_d = 3'b010;
          state_d  = IDLE;
        end
      end
      PASS: begin
        if (take) begin
          out_valid_d = 1'b1;
          out_data_d  = dl_q[DL_LEN-1];
        end else if (timeout) begin
          state_d = FLUSH;
        end
      end
      DROP: begin
        if (timeout) begin
          done_d   = 1'b1;
          status_d = {1'b1, len_bad, fcs_bad};
          state_d  = IDLE;
        end
      end
      FLUSH: begin
        // Oldest byte is the last payload byte; the four younger ones are the FCS.
        out_valid_d = 1'b1;
        out_data_d  = dl_q[DL_LEN-1];
        out_last_d  = 1'b1;
        out_user_d  = fcs_bad || len_bad;
        done_d      = 1'b1;
        status_d    = {1'b0, len_bad, fcs_bad};
        gap_cnt_d   = 16'd0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) begin
      state_q <= IDLE;
      for (int i = 0; i < DL_LEN; i++) dl_q[i] <= 8'h00;
      byte_cnt_q  <= 11'd0;
      gap_cnt_q   <= 16'd0;
      crc_q       <= 32'd0;
      da_match_q  <= 1'b0;
      bc_match_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      crc_q       <= crc_d;
      da_match_q  <= da_match_d;
      bc_match_q  <= bc_match_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      done_q      <= done_d;
      status_q    <= status_d;
    end
  end

  assign o_axis_TREADY  = 1'b1;
  assign o_axis_TVALID  = out_valid_q;
  assign o_axis_TDATA   = out_data_q;
  assign o_axis_TLAST   = out_last_q;
  assign o_axis_TUSER   = out_user_q;
  assign o_frame_done   = done_q;
  assign o_frame_status = status_q;

endmodule
